answer_verifier: RTL and testbench

ANSWER_VERIFIER -- requirements
Module: answer_verifier

---
 rtl/answer_verifier.sv | 155 +++++++++++++++
 tb/tb_answer_verifier.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/answer_verifier.sv
// Two-digit BCD answer checker: compares an entered answer with the current question's answer and shows the result for a fixed time.
// Optional macro ANSWER_VERIFIER_STREAK_EN adds a saturating consecutive-correct counter on output streak.
module answer_verifier #(
    parameter int RESULT_HOLD_CYCLES = 50000000,
    parameter int MAX_ATTEMPTS       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic       verify,
    input  logic       new_question,
    input  logic [6:0] expected_answer,
    output logic       correct,
    output logic       wrong,
    output logic       invalid,
    output logic       correct_led,
    output logic       wrong_led,
    output logic       next_question,
    output logic [2:0] attempts_left,
    output logic [6:0] score,
`ifdef ANSWER_VERIFIER_STREAK_EN
    output logic [6:0] streak,
`endif
    output logic       busy
);

    localparam logic [25:0] HOLD_LAST = 26'(RESULT_HOLD_CYCLES - 1);
    localparam logic [2:0]  ATT_LOAD  = 3'(MAX_ATTEMPTS);
    localparam logic [6:0]  SAT_MAX   = 7'd99;

    typedef enum logic [2:0] {
        WAIT_Q   = 3'd0,
        ARMED    = 3'd1,
        CHECK    = 3'd2,
        SHOW_OK  = 3'd3,
        SHOW_BAD = 3'd4
    } state_t;

    state_t      state_reg;
    logic [3:0]  d1_reg;
    logic [3:0]  d2_reg;
    logic [6:0]  answer_reg;
    logic [25:0] hold_reg;

    logic [6:0] entered;
    logic       digit_bad;
    logic       hold_done;

    // Width is 7 bits so 9*10+9 fits; out-of-range digits are rejected before the compare matters.
    assign entered   = ({3'b000, d1_reg} * 7'd10) + {3'b000, d2_reg};
    assign digit_bad = (d1_reg > 4'd9) || (d2_reg > 4'd9);
    assign hold_done = (hold_reg >= HOLD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= WAIT_Q;
            d1_reg        <= 4'd0;
            d2_reg        <= 4'd0;
            answer_reg    <= 7'd0;
            hold_reg      <= 26'd0;
            correct       <= 1'b0;
            wrong         <= 1'b0;
            invalid       <= 1'b0;
            correct_led   <= 1'b0;
            wrong_led     <= 1'b0;
            next_question <= 1'b0;
            attempts_left <= 3'd0;
            score         <= 7'd0;
            busy          <= 1'b1;
`ifdef ANSWER_VERIFIER_STREAK_EN
            streak        <= 7'd0;
`endif
        end else begin
            correct       <= 1'b0;
            wrong         <= 1'b0;
            invalid       <= 1'b0;
            next_question <= 1'b0;
            case (state_reg)
                WAIT_Q: begin
                    if (new_question) begin
                        answer_reg    <= expected_answer;
                        attempts_left <= ATT_LOAD;
                        state_reg     <= ARMED;
                        busy          <= 1'b0;
                    end
                end
                ARMED: begin
                    // A verify in the same cycle as new_question takes priority; the new answer is dropped.
                    if (verify) begin
                        d1_reg    <= digit1;
                        d2_reg    <= digit2;
                        state_reg <= CHECK;
                        busy      <= 1'b1;
                    end else if (new_question) begin
                        answer_reg    <= expected_answer;
                        attempts_left <= ATT_LOAD;
                    end
                end
                CHECK: begin
                    hold_reg <= 26'd0;
                    if (digit_bad) begin
                        invalid   <= 1'b1;
                        state_reg <= ARMED;
                        busy      <= 1'b0;
                    end else if (entered == answer_reg) begin
                        correct     <= 1'b1;
                        correct_led <= 1'b1;
                        score       <= (score >= SAT_MAX) ? SAT_MAX : score + 7'd1;
`ifdef ANSWER_VERIFIER_STREAK_EN
                        streak      <= (streak >= SAT_MAX) ? SAT_MAX : streak + 7'd1;
`endif
                        state_reg   <= SHOW_OK;
                    end else begin
                        wrong         <= 1'b1;
                        wrong_led     <= 1'b1;
                        attempts_left <= (attempts_left != 3'd0) ? attempts_left - 3'd1 : 3'd0;
`ifdef ANSWER_VERIFIER_STREAK_EN
                        streak        <= 7'd0;
`endif
                        state_reg     <= SHOW_BAD;
                    end
                end
                SHOW_OK: begin
                    if (hold_done) begin
                        correct_led   <= 1'b0;
                        next_question <= 1'b1;
                        state_reg     <= WAIT_Q;
                    end else begin
                        hold_reg <= hold_reg + 26'd1;
                    end
                end
                SHOW_BAD: begin
                    if (hold_done) begin
                        wrong_led <= 1'b0;
                        if (attempts_left == 3'd0) begin
                            next_question <= 1'b1;
                            state_reg     <= WAIT_Q;
                        end else begin
                            state_reg <= ARMED;
                            busy      <= 1'b0;
                        end
                    end else begin
                        hold_reg <= hold_reg + 26'd1;
                    end
                end
                default: begin
                    state_reg <= WAIT_Q;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_answer_verifier.sv
// Directed and randomized bench for answer_verifier with a transaction-level quiz model.
module tb_answer_verifier;

    localparam int HOLD = 4;
    localparam int MAXA = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit1, digit2;
    logic       verify, new_question;
    logic [6:0] expected_answer;
    logic       correct, wrong, invalid, correct_led, wrong_led, next_question, busy;
    logic [2:0] attempts_left;
    logic [6:0] score;
`ifdef ANSWER_VERIFIER_STREAK_EN
    logic [6:0] streak;
`endif

    always #5 clk = ~clk;

    answer_verifier #(.RESULT_HOLD_CYCLES(HOLD), .MAX_ATTEMPTS(MAXA)) dut (
        .clk(clk), .reset(reset), .digit1(digit1), .digit2(digit2),
        .verify(verify), .new_question(new_question), .expected_answer(expected_answer),
        .correct(correct), .wrong(wrong), .invalid(invalid),
        .correct_led(correct_led), .wrong_led(wrong_led), .next_question(next_question),
        .attempts_left(attempts_left), .score(score),
`ifdef ANSWER_VERIFIER_STREAK_EN
        .streak(streak),
`endif
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    // Quiz model: which phase we are in plus the bookkeeping numbers.
    bit m_armed;
    int m_ans, m_att, m_score, m_streak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input bit c, input bit w, input bit i,
                             input bit cl, input bit wl, input bit nq);
        chk({tag, ".correct"}, correct, c);
        chk({tag, ".wrong"}, wrong, w);
        chk({tag, ".invalid"}, invalid, i);
        chk({tag, ".correct_led"}, correct_led, cl);
        chk({tag, ".wrong_led"}, wrong_led, wl);
        chk({tag, ".next_question"}, next_question, nq);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".score"}, score, m_score);
        chk({tag, ".attempts_left"}, attempts_left, m_att);
`ifdef ANSWER_VERIFIER_STREAK_EN
        chk({tag, ".streak"}, streak, m_streak);
`endif
    endtask

    task automatic new_q(input int ans);
        new_question = 1'b1;
        expected_answer = 7'(ans);
        tick();
        new_question = 1'b0;
        expected_answer = 7'($urandom_range(0, 99));
        m_ans = ans;
        m_att = MAXA;
        m_armed = 1'b1;
        chk_flags("newq", 0, 0, 0, 0, 0, 0);
        chk("newq.busy", busy, 0);
        chk_counts("newq");
        $display("[TB] new_question answer=%0d attempts=%0d", ans, attempts_left);
    endtask

    // One verify transaction from ARMED, followed through the whole result display.
    task automatic do_verify(input int d1, input int d2, input bit with_newq, input bit spam);
        bit bad, ok;
        bad = (d1 > 9) || (d2 > 9);
        ok  = !bad && ((d1 * 10 + d2) == m_ans);
        digit1 = 4'(d1);
        digit2 = 4'(d2);
        verify = 1'b1;
        if (with_newq) begin
            new_question = 1'b1;
            expected_answer = 7'($urandom_range(0, 99));
        end
        tick();
        verify = 1'b0;
        new_question = 1'b0;
        digit1 = 4'($urandom_range(0, 15));
        digit2 = 4'($urandom_range(0, 15));
        chk_flags("check_cycle", 0, 0, 0, 0, 0, 0);
        chk("check_cycle.busy", busy, 1);
        tick();
        if (bad) begin
            chk_flags("invalid_pulse", 0, 0, 1, 0, 0, 0);
            chk("invalid_pulse.busy", busy, 0);
            chk_counts("invalid_pulse");
        end else begin
            if (ok) begin
                m_score  = (m_score >= 99) ? 99 : m_score + 1;
                m_streak = (m_streak >= 99) ? 99 : m_streak + 1;
            end else begin
                m_att    = (m_att > 0) ? m_att - 1 : 0;
                m_streak = 0;
            end
            chk_flags("result_pulse", ok, !ok, 0, ok, !ok, 0);
            chk("result_pulse.busy", busy, 1);
            chk_counts("result_pulse");
            for (int k = 1; k < HOLD; k++) begin
                if (spam) begin
                    verify = 1'($urandom_range(0, 1));
                    new_question = 1'($urandom_range(0, 1));
                    digit1 = 4'(m_ans / 10);
                    digit2 = 4'(m_ans % 10);
                end
                tick();
                chk_flags("display", 0, 0, 0, ok, !ok, 0);
                chk("display.busy", busy, 1);
            end
            verify = 1'b0;
            new_question = 1'b0;
            tick();
            m_armed = !ok && (m_att > 0);
            chk_flags("expiry", 0, 0, 0, 0, 0, !m_armed);
            chk("expiry.busy", busy, !m_armed);
            chk_counts("expiry");
        end
        $display("[TB] verify %0d,%0d answer=%0d newq=%0d spam=%0d -> c=%0d w=%0d i=%0d score=%0d att=%0d",
                 d1, d2, m_ans, with_newq, spam, ok, !ok && !bad, bad, score, attempts_left);
    endtask

    initial begin
        reset = 1'b1;
        digit1 = 4'd0;
        digit2 = 4'd0;
        verify = 1'b0;
        new_question = 1'b0;
        expected_answer = 7'd0;
        m_armed = 1'b0;
        m_ans = 0;
        m_att = 0;
        m_score = 0;
        m_streak = 0;
        tick();
        tick();
        reset = 1'b0;
        chk_flags("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.busy", busy, 1);
        chk_counts("reset");
        $display("[TB] reset released score=%0d att=%0d busy=%0d", score, attempts_left, busy);

        // verify in WAIT_Q must be ignored
        digit1 = 4'd0;
        digit2 = 4'd0;
        verify = 1'b1;
        tick();
        verify = 1'b0;
        tick();
        tick();
        chk_flags("waitq_verify", 0, 0, 0, 0, 0, 0);
        chk("waitq_verify.busy", busy, 1);
        $display("[TB] verify while waiting ignored busy=%0d", busy);

        new_q(42);
        do_verify(4, 2, 0, 0);
        new_q(42);
        do_verify(2, 4, 0, 0);
        do_verify(2, 4, 0, 0);
        new_q(42);
        do_verify(10, 3, 0, 0);
        do_verify(4, 2, 0, 1);
        new_q(17);
        do_verify(1, 7, 1, 0);
        new_q(55);
        new_q(63);
        do_verify(6, 3, 1, 1);

        for (int n = 0; n < 40; n++) begin
            int a, d1, d2, mode;
            if (!m_armed || $urandom_range(0, 4) == 0) new_q($urandom_range(0, 99));
            a = m_ans;
            mode = $urandom_range(0, 3);
            if (mode < 2) begin
                d1 = a / 10;
                d2 = a % 10;
            end else if (mode == 2) begin
                d1 = $urandom_range(0, 9);
                d2 = $urandom_range(0, 9);
            end else begin
                d1 = $urandom_range(0, 15);
                d2 = $urandom_range(0, 15);
            end
            do_verify(d1, d2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset in the second display cycle of a wrong answer
        new_q(42);
        digit1 = 4'd2;
        digit2 = 4'd4;
        verify = 1'b1;
        tick();
        verify = 1'b0;
        tick();
        chk("midreset.wrong", wrong, 1);
        tick();
        chk("midreset.wrong_led", wrong_led, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_armed = 1'b0;
        m_att = 0;
        m_score = 0;
        m_streak = 0;
        chk_flags("midreset", 0, 0, 0, 0, 0, 0);
        chk("midreset.busy", busy, 1);
        chk_counts("midreset");
        tick();
        chk("midreset_after.next_question", next_question, 0);
        chk("midreset_after.busy", busy, 1);
        $display("[TB] reset during wrong display score=%0d led=%0d", score, wrong_led);

        for (int n = 0; n < 100; n++) begin
            int a;
            a = $urandom_range(0, 99);
            new_q(a);
            do_verify(a / 10, a % 10, 0, 0);
        end
        chk("saturate.score", score, 99);
        new_q(5);
        do_verify(0, 6, 0, 0);
        chk("after_wrong.score", score, 99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
